aes_decryption_core: RTL and testbench



---
 rtl/aes_decryption_core_if.sv | 20 ++
 rtl/aes_decryption_core.sv | 235 +++++++++++++++++++++++
 tb/tb_aes_decryption_core.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_decryption_core_if.sv
// Request/response bundle for aes_decryption_core: block and key in, plaintext out.
// start is sampled only while the core is idle; done is a one-cycle pulse qualifying plaintext, busy covers the run.
interface aes_decryption_core_if;
    logic         start;
    logic [127:0] ciphertext;
    logic [127:0] key;
    logic [127:0] plaintext;
    logic         done;
    logic         busy;

    modport master (
        output start, ciphertext, key,
        input  plaintext, done, busy
    );

    modport slave (
        input  start, ciphertext, key,
        output plaintext, done, busy
    );
endinterface

// File: rtl/aes_decryption_core.sv
// Iterative AES-128 decryptor: forward schedule to K10, then nine inverse rounds and a final round.
// Optional macro AES_DEC_KEY_CACHE_EN keeps the last key's K10 so a repeated key skips KEYEXP.
module aes_decryption_core (
    input  logic                 clk,
    input  logic                 reset_n,
    aes_decryption_core_if.slave bus,
    output logic [2:0]           dbg_state
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        KEYEXP = 3'd1,
        INIT   = 3'd2,
        ROUND  = 3'd3,
        FINAL  = 3'd4
    } fsm_t;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    fsm_t         fsm_q;
    logic [127:0] state_q;
    logic [127:0] key_q;
    logic [127:0] plaintext_q;
    logic [3:0]   round_q;
    logic         done_q;
    logic         busy_q;

`ifdef AES_DEC_KEY_CACHE_EN
    logic [127:0] last_key_q;
    logic [127:0] k10_q;
    logic         cache_valid_q;
`endif

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rcon_of(input logic [3:0] idx);
        case (idx)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // Row r of the column-major state rotates right by r byte positions.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r)&3)+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a   [4];
        logic [7:0] m9  [4];
        logic [7:0] m11 [4];
        logic [7:0] m13 [4];
        logic [7:0] m14 [4];
        logic [7:0] x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            a[i]   = col[31-8*i -: 8];
            x2     = xt(a[i]);
            x4     = xt(x2);
            x8     = xt(x4);
            m9[i]  = x8 ^ a[i];
            m11[i] = x8 ^ x2 ^ a[i];
            m13[i] = x8 ^ x4 ^ a[i];
            m14[i] = x8 ^ x4 ^ x2;
        end
        return {m14[0] ^ m11[1] ^ m13[2] ^ m9[3],
                m9[0]  ^ m14[1] ^ m11[2] ^ m13[3],
                m13[0] ^ m9[1]  ^ m14[2] ^ m11[3],
                m11[0] ^ m13[1] ^ m9[2]  ^ m14[3]};
    endfunction

    logic [127:0] isr, isb, ark, imc, key_next;
    logic [31:0]  sw_in, rot, sw_out;
    logic [3:0]   rcon_idx;

    assign isr = inv_shift_rows(state_q);

    always_comb begin
        isb = '0;
        imc = '0;
        for (int i = 0; i < 16; i++) begin
            isb[127-8*i -: 8] = INV_SBOX[isr[127-8*i -: 8]];
        end
        ark = isb ^ key_q;
        for (int c = 0; c < 4; c++) begin
            imc[127-32*c -: 32] = inv_mix_col(ark[127-32*c -: 32]);
        end
    end

    // One set of four forward S-boxes serves both schedule directions: going
    // backwards, the word to substitute is the recovered w3 = w3' ^ w2'.
    always_comb begin
        rcon_idx = round_q;
        sw_in    = key_q[31:0] ^ key_q[63:32];
        key_next = key_q;
        sw_out   = '0;
        if (fsm_q == KEYEXP) begin
            rcon_idx = round_q + 4'd1;
            sw_in    = key_q[31:0];
        end else if (fsm_q == INIT) begin
            rcon_idx = 4'd10;
        end
        rot = {sw_in[23:0], sw_in[31:24]};
        for (int i = 0; i < 4; i++) begin
            sw_out[31-8*i -: 8] = SBOX[rot[31-8*i -: 8]];
        end
        sw_out = sw_out ^ {rcon_of(rcon_idx), 24'h0};
        if (fsm_q == KEYEXP) begin
            key_next[127:96] = key_q[127:96] ^ sw_out;
            key_next[95:64]  = key_q[95:64] ^ key_next[127:96];
            key_next[63:32]  = key_q[63:32] ^ key_next[95:64];
            key_next[31:0]   = key_q[31:0] ^ key_next[63:32];
        end else begin
            key_next[127:96] = key_q[127:96] ^ sw_out;
            key_next[95:64]  = key_q[95:64] ^ key_q[127:96];
            key_next[63:32]  = key_q[63:32] ^ key_q[95:64];
            key_next[31:0]   = key_q[31:0] ^ key_q[63:32];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fsm_q         <= IDLE;
            state_q       <= '0;
            key_q         <= '0;
            plaintext_q   <= '0;
            round_q       <= '0;
            done_q        <= 1'b0;
            busy_q        <= 1'b0;
`ifdef AES_DEC_KEY_CACHE_EN
            last_key_q    <= '0;
            k10_q         <= '0;
            cache_valid_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (fsm_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q <= bus.ciphertext;
                        busy_q  <= 1'b1;
                        round_q <= 4'd0;
`ifdef AES_DEC_KEY_CACHE_EN
                        if (cache_valid_q && (bus.key == last_key_q)) begin
                            key_q <= k10_q;
                            fsm_q <= INIT;
                        end else begin
                            key_q         <= bus.key;
                            last_key_q    <= bus.key;
                            cache_valid_q <= 1'b0;
                            fsm_q         <= KEYEXP;
                        end
`else
                        key_q <= bus.key;
                        fsm_q <= KEYEXP;
`endif
                    end
                end
                KEYEXP: begin
                    key_q   <= key_next;
                    round_q <= round_q + 4'd1;
                    if (round_q == 4'd9) begin
                        fsm_q <= INIT;
`ifdef AES_DEC_KEY_CACHE_EN
                        k10_q         <= key_next;
                        cache_valid_q <= 1'b1;
`endif
                    end
                end
                INIT: begin
                    state_q <= state_q ^ key_q;
                    key_q   <= key_next;
                    round_q <= 4'd9;
                    fsm_q   <= ROUND;
                end
                ROUND: begin
                    state_q <= imc;
                    key_q   <= key_next;
                    round_q <= round_q - 4'd1;
                    if (round_q == 4'd1) begin
                        fsm_q <= FINAL;
                    end
                end
                FINAL: begin
                    plaintext_q <= ark;
                    done_q      <= 1'b1;
                    busy_q      <= 1'b0;
                    fsm_q       <= IDLE;
                end
                default: fsm_q <= IDLE;
            endcase
        end
    end

    assign bus.plaintext = plaintext_q;
    assign bus.done      = done_q;
    assign bus.busy      = busy_q;
    assign dbg_state     = fsm_q;
endmodule

// File: tb/tb_aes_decryption_core.sv
// Scoreboarded bench for aes_decryption_core: FIPS-197 vectors, boundary cases and round trips.
// Honours AES_DEC_KEY_CACHE_EN for the expected latency of repeated keys.
module tb_aes_decryption_core;
    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic       clk = 1'b0;
    logic       reset_n;
    logic [2:0] dbg_state;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    logic       done_prev = 1'b0;

    logic [127:0] exp_q[$];
    int           exp_cyc_q[$];

    logic         model_valid = 1'b0;
    logic [127:0] model_key = '0;

    aes_decryption_core_if bus();

    aes_decryption_core dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Reference encryptor used to build round-trip vectors
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t, w0, w1, w2, w3;
        t  = {k[23:0], k[31:24]};
        t  = {SBOX[t[31:24]], SBOX[t[23:16]], SBOX[t[15:8]], SBOX[t[7:0]]} ^ {rc, 24'h0};
        w0 = k[127:96] ^ t;
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] encrypt(input logic [127:0] pt, input logic [127:0] key);
        logic [7:0]   rcs [10];
        logic [127:0] s, o, k;
        logic [7:0]   a0, a1, a2, a3;
        rcs = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
        k = key;
        s = pt ^ key;
        for (int r = 1; r <= 10; r++) begin
            k = key_step(k, rcs[r-1]);
            for (int i = 0; i < 16; i++) s[127-8*i -: 8] = SBOX[s[127-8*i -: 8]];
            o = '0;
            for (int c = 0; c < 4; c++)
                for (int w = 0; w < 4; w++)
                    o[127-8*(4*c+w) -: 8] = s[127-8*(4*((c+w)&3)+w) -: 8];
            s = o;
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[127-32*c -: 8];
                    a1 = s[119-32*c -: 8];
                    a2 = s[111-32*c -: 8];
                    a3 = s[103-32*c -: 8];
                    s[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
            end
            s = s ^ k;
        end
        return s;
    endfunction

    function automatic int exp_lat(input logic [127:0] k);
        int l;
        l = 21;
`ifdef AES_DEC_KEY_CACHE_EN
        if (model_valid && (k == model_key)) l = 11;
        model_valid = 1'b1;
        model_key   = k;
`endif
        return l;
    endfunction

    // Driver: called on a negedge while the core is idle
    task automatic issue(input logic [127:0] ct, input logic [127:0] k, input logic [127:0] pt,
                         output int c0);
        int lat;
        lat = exp_lat(k);
        bus.ciphertext = ct;
        bus.key        = k;
        bus.start      = 1'b1;
        @(posedge clk);
        #1;
        c0 = cyc;
        exp_q.push_back(pt);
        exp_cyc_q.push_back(c0 + lat);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!bus.done && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!bus.done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout got=no_done exp=done within 60 cycles");
        end else begin
            check("busy_at_done", {127'd0, bus.busy}, 128'd0);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        logic [127:0] exp_pt;
        int           exp_c;
        if (reset_n === 1'b1 && bus.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done got=done exp=idle at cycle %0d", cyc);
            end else begin
                exp_pt = exp_q.pop_front();
                exp_c  = exp_cyc_q.pop_front();
                check("plaintext", bus.plaintext, exp_pt);
                check("done_cycle", 128'(cyc), 128'(exp_c));
            end
            check("done_width", {127'd0, done_prev}, 128'd0);
        end
        done_prev = bus.done;
    end

    initial begin
        int c0;
        int lat1;
        int lat2;
        logic [127:0] rk, rpt;
        reset_n        = 1'b0;
        bus.start      = 1'b0;
        bus.ciphertext = '0;
        bus.key        = '0;
        repeat (3) @(negedge clk);
        check("reset_plaintext", bus.plaintext, 128'd0);
        check("reset_done", {127'd0, bus.done}, 128'd0);
        check("reset_busy", {127'd0, bus.busy}, 128'd0);
        reset_n = 1'b1;
        @(negedge clk);

        issue(C1_CT, C1_KEY, C1_PT, c0);
        check("busy_after_start", {127'd0, bus.busy}, 128'd1);
        wait_done();
        issue(B_CT, B_KEY, B_PT, c0);
        wait_done();

        // start pulsed mid-run with another block: must be ignored
        issue(C1_CT, C1_KEY, C1_PT, c0);
        while (cyc < c0 + 4) @(negedge clk);
        bus.start      = 1'b1;
        bus.ciphertext = B_CT;
        bus.key        = B_KEY;
        @(negedge clk);
        bus.start = 1'b0;
        check("busy_during_poke", {127'd0, bus.busy}, 128'd1);
        wait_done();
        repeat (30) @(negedge clk);

        // asynchronous reset during key expansion
        issue(C1_CT, C1_KEY, C1_PT, c0);
        while (cyc < c0 + 7) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midrun_reset_plaintext", bus.plaintext, 128'd0);
        check("midrun_reset_done", {127'd0, bus.done}, 128'd0);
        check("midrun_reset_busy", {127'd0, bus.busy}, 128'd0);
        check("midrun_reset_state", {125'd0, dbg_state}, 128'd0);
        exp_q.delete();
        exp_cyc_q.delete();
        model_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        issue(C1_CT, C1_KEY, C1_PT, c0);
        wait_done();

        issue(B_CT, B_KEY, B_PT, c0);
        wait_done();

        // start held high: same key twice back to back
        lat1 = exp_lat(C1_KEY);
        bus.ciphertext = C1_CT;
        bus.key        = C1_KEY;
        bus.start      = 1'b1;
        @(posedge clk);
        #1;
        c0 = cyc;
        exp_q.push_back(C1_PT);
        exp_cyc_q.push_back(c0 + lat1);
        lat2 = exp_lat(C1_KEY);
        exp_q.push_back(C1_PT);
        exp_cyc_q.push_back(c0 + lat1 + 1 + lat2);
        @(negedge clk);
        wait_done();
        @(negedge clk);
        bus.start = 1'b0;
        wait_done();

        issue(B_CT, B_KEY, B_PT, c0);
        wait_done();

        // round trips through the reference encryptor
        for (int i = 0; i < 8; i++) begin
            rk  = {$urandom, $urandom, $urandom, $urandom};
            rpt = {$urandom, $urandom, $urandom, $urandom};
            issue(encrypt(rpt, rk), rk, rpt, c0);
            wait_done();
        end

        repeat (5) @(negedge clk);
        check("queue_drained", 128'(exp_q.size()), 128'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
